// File: rtl/ft245_pkg.sv
// Shared constants for the FT245 FIFO emulator: byte width, default depth
// and the occupancy-counter width helper.
package ft245_pkg;
  localparam int FT_DATA_W    = 8;
  localparam int FT_DEPTH_DEF = 16;

  // Level counter must reach DEPTH itself, hence one bit more than the pointers.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/ft245_fifo_emu_byte_fifo.sv
// Single-clock byte FIFO with first-word fall-through head, occupancy level
// and full/empty flags. Push while full and pop while empty are ignored.
module byte_fifo
  import ft245_pkg::*;
#(
  parameter  int DEPTH = FT_DEPTH_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = lvl_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic [FT_DATA_W-1:0] din_i,
  input  logic                 pop_i,
  output logic [FT_DATA_W-1:0] head_o,
  output logic [LW-1:0]        level_o,
  output logic                 full_o,
  output logic                 empty_o
);
  logic [FT_DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]        wptr_q, rptr_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage carries no reset; only pointers and level define contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/ft245_fifo_emu.sv
// FT245-style FIFO front end for the JTAG engine: buffers RX/TX byte streams
// and turns nrd/wr strobes into registered flag and data-bus behaviour.
module ft245_fifo_emu
  import ft245_pkg::*;
#(
  parameter  int DEPTH = FT_DEPTH_DEF,
  localparam int LW    = lvl_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FT_DATA_W-1:0] rx_tdata,
  input  logic                 rx_tvalid,
  output logic                 rx_tready,
  output logic [FT_DATA_W-1:0] tx_tdata,
  output logic                 tx_tvalid,
  input  logic                 tx_tready,
  output logic                 nrxf,
  output logic                 ntxe,
  input  logic                 nrd,
  input  logic                 wr,
  input  logic [FT_DATA_W-1:0] ft_d_i,
  output logic [FT_DATA_W-1:0] ft_d_o,
  output logic                 ft_d_oe,
  output logic [LW-1:0]        rx_level,
  output logic [LW-1:0]        tx_level,
  output logic                 err_unf,
  output logic                 err_ovf
);
  logic                 nrd_q, wr_q;
  logic                 nrxf_q, nrxf_d, ntxe_q, ntxe_d;
  logic                 oe_q, oe_d, unf_q, unf_d, ovf_q, ovf_d;
  logic [FT_DATA_W-1:0] do_q, do_d, rx_head;
  logic                 rx_full, rx_empty, tx_full, tx_empty;
  logic                 rd_start, rd_end, wr_end, rx_pop, tx_push;

  assign rd_start = nrd_q & ~nrd;
  assign rd_end   = ~nrd_q & nrd;
  assign wr_end   = wr_q & ~wr;
  assign rx_pop   = rd_end & ~rx_empty;
  assign tx_push  = wr_end & ~tx_full;

  byte_fifo #(.DEPTH(DEPTH)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_tvalid & rx_tready),
    .din_i   (rx_tdata),
    .pop_i   (rx_pop),
    .head_o  (rx_head),
    .level_o (rx_level),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_push),
    .din_i   (ft_d_i),
    .pop_i   (tx_tvalid & tx_tready),
    .head_o  (tx_tdata),
    .level_o (tx_level),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  assign rx_tready = ~rx_full;
  assign tx_tvalid = ~tx_empty;

  // Flags are forced high through the strobe and its closing cycle so the
  // engine never sees a stale "available" indication after a transfer.
  always_comb begin
    nrxf_d = (~nrd | rd_end) ? 1'b1 : rx_empty;
    ntxe_d = (wr | wr_end)   ? 1'b1 : tx_full;
    do_d   = do_q;
    oe_d   = oe_q;
    if (rd_start) begin
      do_d = rx_empty ? '0 : rx_head;
      oe_d = 1'b1;
    end
    if (rd_end) oe_d = 1'b0;
    unf_d = unf_q | (rd_end & rx_empty);
    ovf_d = ovf_q | (wr_end & tx_full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nrd_q  <= 1'b1;
      wr_q   <= 1'b0;
      nrxf_q <= 1'b1;
      ntxe_q <= 1'b1;
      do_q   <= '0;
      oe_q   <= 1'b0;
      unf_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      nrd_q  <= nrd;
      wr_q   <= wr;
      nrxf_q <= nrxf_d;
      ntxe_q <= ntxe_d;
      do_q   <= do_d;
      oe_q   <= oe_d;
      unf_q  <= unf_d;
      ovf_q  <= ovf_d;
    end
  end

  assign nrxf    = nrxf_q;
  assign ntxe    = ntxe_q;
  assign ft_d_o  = do_q;
  assign ft_d_oe = oe_q;
  assign err_unf = unf_q;
  assign err_ovf = ovf_q;
endmodule

// File: tb/tb_ft245_fifo_emu.sv
// Bench for ft245_fifo_emu: queue-based reference model compared every cycle,
// directed engine transactions with literal expectations, then random traffic.
module tb_ft245_fifo_emu;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic [7:0]    rx_tdata = '0, ft_d_i = '0;
  logic          rx_tvalid = 1'b0, tx_tready = 1'b0, nrd = 1'b1, wr = 1'b0;
  logic          rx_tready, tx_tvalid, nrxf, ntxe, ft_d_oe, err_unf, err_ovf;
  logic [7:0]    tx_tdata, ft_d_o;
  logic [LW-1:0] rx_level, tx_level;

  int nchk = 0, nerr = 0;

  ft245_fifo_emu #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .nrxf(nrxf), .ntxe(ntxe), .nrd(nrd), .wr(wr),
    .ft_d_i(ft_d_i), .ft_d_o(ft_d_o), .ft_d_oe(ft_d_oe),
    .rx_level(rx_level), .tx_level(tx_level),
    .err_unf(err_unf), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Reference model: two byte queues plus the strobe-protocol rules.
  logic [7:0] rxq[$], txq[$];
  logic       p_nrd = 1'b1, p_wr = 1'b0;
  logic       m_nrxf = 1'b1, m_ntxe = 1'b1, m_oe = 1'b0, m_unf = 1'b0, m_ovf = 1'b0;
  logic [7:0] m_do = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxq.delete(); txq.delete();
      p_nrd = 1'b1; p_wr = 1'b0;
      m_nrxf = 1'b1; m_ntxe = 1'b1; m_oe = 1'b0; m_do = '0;
      m_unf = 1'b0; m_ovf = 1'b0;
    end else begin
      bit rs, re, we, rx_e, tx_f, tx_e, rx_pu;
      rs    = p_nrd && !nrd;
      re    = !p_nrd && nrd;
      we    = p_wr && !wr;
      rx_e  = (rxq.size() == 0);
      tx_e  = (txq.size() == 0);
      tx_f  = (txq.size() == DEPTH);
      rx_pu = rx_tvalid && (rxq.size() < DEPTH);
      m_nrxf = (!nrd || re) ? 1'b1 : rx_e;
      m_ntxe = (wr || we) ? 1'b1 : tx_f;
      if (rs) begin m_do = rx_e ? 8'h00 : rxq[0]; m_oe = 1'b1; end
      if (re) begin
        m_oe = 1'b0;
        if (rx_e) m_unf = 1'b1; else void'(rxq.pop_front());
      end
      if (rx_pu) rxq.push_back(rx_tdata);
      if (tx_tready && !tx_e) void'(txq.pop_front());
      if (we) begin
        if (tx_f) m_ovf = 1'b1; else txq.push_back(ft_d_i);
      end
      p_nrd = nrd; p_wr = wr;
    end
  end

  always @(negedge clk) begin
    chk("nrxf", 32'(nrxf), 32'(m_nrxf));
    chk("ntxe", 32'(ntxe), 32'(m_ntxe));
    chk("ft_d_oe", 32'(ft_d_oe), 32'(m_oe));
    chk("ft_d_o", 32'(ft_d_o), 32'(m_do));
    chk("rx_tready", 32'(rx_tready), 32'(rxq.size() < DEPTH));
    chk("tx_tvalid", 32'(tx_tvalid), 32'(txq.size() != 0));
    if (txq.size() != 0) chk("tx_tdata", 32'(tx_tdata), 32'(txq[0]));
    chk("rx_level", 32'(rx_level), 32'(rxq.size()));
    chk("tx_level", 32'(tx_level), 32'(txq.size()));
    chk("err_unf", 32'(err_unf), 32'(m_unf));
    chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
  end

  task automatic wait_low(input bit is_rx);
    int i;
    for (i = 0; i < 64; i++) begin
      if (is_rx ? !nrxf : !ntxe) break;
      tick();
    end
    if (i == 64) begin
      nchk++; nerr++;
      $display("FAIL %s wait: flag stayed high for 64 cycles", is_rx ? "nrxf" : "ntxe");
    end
  endtask

  // Engine read: wait for data, hold nrd low two cycles, latch, release.
  task automatic eng_read(output logic [7:0] b);
    wait_low(1'b1);
    nrd = 1'b0; tick(); tick();
    chk("rd_oe", 32'(ft_d_oe), 32'd1);
    b = ft_d_o;
    nrd = 1'b1; tick();
  endtask

  task automatic eng_write(input logic [7:0] v, input bit wait_ok);
    if (wait_ok) wait_low(1'b0);
    ft_d_i = v; wr = 1'b1; tick(); tick();
    wr = 1'b0; tick();
  endtask

  task automatic rx_push(input logic [7:0] v);
    rx_tvalid = 1'b1; rx_tdata = v; tick(); rx_tvalid = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] exp3 [3];
    exp3[0] = 8'h81; exp3[1] = 8'h02; exp3[2] = 8'h55;

    #1 rst_n = 1'b0;
    #12;
    chk("rst_nrxf", 32'(nrxf), 32'd1);
    chk("rst_ntxe", 32'(ntxe), 32'd1);
    chk("rst_oe", 32'(ft_d_oe), 32'd0);
    chk("rst_do", 32'(ft_d_o), 32'h00);
    chk("rst_txv", 32'(tx_tvalid), 32'd0);
    chk("rst_lvl", 32'({rx_level, tx_level}), 32'd0);
    chk("rst_err", 32'({err_unf, err_ovf}), 32'd0);
    tick(); rst_n = 1'b1; tick(); tick();
    chk("idle_rdy", 32'(rx_tready), 32'd1);
    chk("idle_ntxe", 32'(ntxe), 32'd0);

    // Single byte: nrxf falls one cycle after the push edge.
    rx_push(8'hA5);
    chk("a5_nrxf_e", 32'(nrxf), 32'd1);
    chk("a5_lvl", 32'(rx_level), 32'd1);
    tick();
    chk("a5_nrxf_e1", 32'(nrxf), 32'd0);
    eng_read(b);
    chk("a5_data", 32'(b), 32'hA5);
    tick();
    chk("a5_nrxf_after", 32'(nrxf), 32'd1);
    chk("a5_lvl_after", 32'(rx_level), 32'd0);

    // Back-to-back pushes, three ordered reads with a gap in nrxf.
    rx_push(8'h81); rx_push(8'h02); rx_push(8'h55);
    for (int i = 0; i < 3; i++) begin
      eng_read(b);
      chk("seq_data", 32'(b), 32'(exp3[i]));
      chk("seq_gap", 32'(nrxf), 32'd1);
    end
    tick();
    chk("seq_lvl", 32'(rx_level), 32'd0);

    // Engine write visible to the endpoint one cycle after wr falls.
    eng_write(8'h3C, 1'b1);
    chk("w_txv", 32'(tx_tvalid), 32'd1);
    chk("w_txd", 32'(tx_tdata), 32'h3C);
    tick();
    chk("w_ntxe", 32'(ntxe), 32'd0);
    tx_tready = 1'b1; tick(); tx_tready = 1'b0;
    chk("w_drained", 32'(tx_level), 32'd0);

    // Fill TX, overflow once, drain in order.
    for (int i = 0; i < DEPTH; i++) eng_write(8'(i), 1'b1);
    tick();
    chk("full_ntxe", 32'(ntxe), 32'd1);
    chk("full_lvl", 32'(tx_level), 32'(DEPTH));
    eng_write(8'hEE, 1'b0);
    chk("ovf_flag", 32'(err_ovf), 32'd1);
    chk("ovf_lvl", 32'(tx_level), 32'(DEPTH));
    tx_tready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_v", 32'(tx_tvalid), 32'd1);
      chk("drain_d", 32'(tx_tdata), 32'(i));
      tick();
    end
    tx_tready = 1'b0;
    chk("drain_empty", 32'(tx_tvalid), 32'd0);

    // Read strobe with RX empty.
    nrd = 1'b0; tick(); tick();
    chk("unf_do", 32'(ft_d_o), 32'h00);
    chk("unf_oe", 32'(ft_d_oe), 32'd1);
    nrd = 1'b1; tick();
    chk("unf_flag", 32'(err_unf), 32'd1);
    chk("unf_lvl", 32'(rx_level), 32'd0);
    chk("unf_oe_off", 32'(ft_d_oe), 32'd0);

    // Random traffic; the second phase starves tx_tready to reach TX full.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        rx_tvalid = 1'($urandom_range(0, 1));
        rx_tdata  = 8'($urandom);
        tx_tready = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) == 0) nrd = ~nrd;
        if ($urandom_range(0, 3) == 0) wr = ~wr;
        ft_d_i = 8'($urandom);
        tick();
      end
    end
    rx_tvalid = 1'b0; tx_tready = 1'b0; nrd = 1'b1; wr = 1'b0;
    tick(); tick(); tick();

    // Asynchronous reset in the middle of a read.
    rx_push(8'h3C); tick();
    nrd = 1'b0; tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    chk("mid_nrxf", 32'(nrxf), 32'd1);
    chk("mid_oe", 32'(ft_d_oe), 32'd0);
    chk("mid_rxlvl", 32'(rx_level), 32'd0);
    chk("mid_txlvl", 32'(tx_level), 32'd0);
    nrd = 1'b1; tick();
    rst_n = 1'b1; tick();
    rx_push(8'h77);
    eng_read(b);
    chk("post_rst_data", 32'(b), 32'h77);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
